// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the fish game round sequencer.
//   game_state_t - round sequencer states
//   NUM_FISH     - number of fish sprites drawn by the colour mapper
//   score_t      - binary score as presented to the score digit renderer
//   fish_count() - number of set bits in a per-fish mask
package game_pkg;

    localparam int unsigned NUM_FISH = 9;

    typedef enum logic [1:0] {IDLE, PLAY, U1WIN, U2WIN} game_state_t;

    typedef logic [7:0] score_t;

    // Points earned when a user swallows every fish set in the mask.
    function automatic score_t fish_count(input logic [NUM_FISH-1:0] mask);
        score_t n;
        n = '0;
        for (int i = 0; i < NUM_FISH; i++) begin
            n = n + score_t'(mask[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fish_respawn_timer.sv
// fish_respawn_timer: hidden/visible flag for one fish sprite plus the frame
// counter that brings it back after RESPAWN_FRAMES frame ticks.
// Ports:
//   Clk, Reset_n  clock, asynchronous active-low reset
//   clear         force visible and zero the counter (new round)
//   hide          fish was eaten this cycle (only honoured while visible)
//   frame_tick    one-cycle frame pulse, already gated to the PLAY state
//   exist         1 = fish hidden (mapper draws it when 0)
module fish_respawn_timer #(
    parameter int unsigned RESPAWN_FRAMES = 120
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic clear,
    input  logic hide,
    input  logic frame_tick,
    output logic exist
);

    localparam int unsigned CW = $clog2(RESPAWN_FRAMES + 1);

    logic [CW-1:0] cnt;

    // The fish reappears on the edge that consumes its RESPAWN_FRAMES-th tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            exist <= 1'b0;
            cnt   <= '0;
        end else if (clear) begin
            exist <= 1'b0;
            cnt   <= '0;
        end else if (!exist) begin
            if (hide) begin
                exist <= 1'b1;
                cnt   <= '0;
            end
        end else if (frame_tick) begin
            if (cnt == CW'(RESPAWN_FRAMES - 1)) begin
                exist <= 1'b0;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/game_state_controller.sv
// game_state_controller: round sequencer for the fish game. Owns the game
// state, both scores and the sprite exist flags driven to the colour mapper.
// Optional feature macro: GAME_TIME_LIMIT_EN (round timer, ROUND_FRAMES).
// Ports:
//   Clk, Reset_n            clock, asynchronous active-low reset
//   frame_clk               VGA vsync, rising edge = frame tick
//   start_key               start/continue key level, rising edge = press
//   user1_eat, user2_eat    per-fish overlap with user1/user2
//   user1_shark, user2_shark user overlaps the shark
//   is_start                0 = start screen, 1 = round running or finished
//   is_user1win/is_user2win win screen selects
//   score1, score2          binary scores 0..WIN_SCORE
//   fish_exist              1 = fish hidden
//   user1_exist/user2_exist 1 = user eaten by the shark
module game_state_controller
    import game_pkg::*;
#(
    parameter int unsigned WIN_SCORE      = 9,
    parameter int unsigned RESPAWN_FRAMES = 120
`ifdef GAME_TIME_LIMIT_EN
    ,
    parameter int unsigned ROUND_FRAMES   = 3600
`endif
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_clk,
    input  logic                start_key,
    input  logic [NUM_FISH-1:0] user1_eat,
    input  logic [NUM_FISH-1:0] user2_eat,
    input  logic                user1_shark,
    input  logic                user2_shark,
    output logic                is_start,
    output logic                is_user1win,
    output logic                is_user2win,
    output score_t              score1,
    output score_t              score2,
    output logic [NUM_FISH-1:0] fish_exist,
    output logic                user1_exist,
    output logic                user2_exist
);

    localparam score_t WIN = score_t'(WIN_SCORE);

`ifdef GAME_TIME_LIMIT_EN
    localparam int unsigned RW = $clog2(ROUND_FRAMES + 1);
    logic [RW-1:0] round_cnt, round_cnt_next;
`endif

    game_state_t         state, state_next;
    score_t              score1_next, score2_next;
    logic                user1_exist_next, user2_exist_next;
    logic                clear_all, win1, win2;
    logic                frame_tick, key_press, play_tick;
    logic [2:0]          frame_sync, key_sync;
    logic [NUM_FISH-1:0] eat1, eat2, hide;

    // Two-flop synchronisers with a third flop for rising-edge detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_sync <= '0;
            key_sync   <= '0;
        end else begin
            frame_sync <= {frame_sync[1:0], frame_clk};
            key_sync   <= {key_sync[1:0], start_key};
        end
    end

    assign frame_tick = frame_sync[1] & ~frame_sync[2];
    assign key_press  = key_sync[1] & ~key_sync[2];
    assign play_tick  = frame_tick && (state == PLAY);

    // Only visible fish can be eaten; user1 wins a fish both users touch.
    assign eat1 = user1_eat & ~fish_exist;
    assign eat2 = user2_eat & ~fish_exist & ~user1_eat;

    function automatic score_t sat_add(input score_t s, input score_t n);
        score_t sum;
        sum = s + n;
        return (sum > WIN) ? WIN : sum;
    endfunction

    // Next-state, score and exist-flag resolution.
    always_comb begin
        state_next       = state;
        score1_next      = score1;
        score2_next      = score2;
        user1_exist_next = user1_exist;
        user2_exist_next = user2_exist;
        clear_all        = 1'b0;
        hide             = '0;
        win1             = 1'b0;
        win2             = 1'b0;
`ifdef GAME_TIME_LIMIT_EN
        round_cnt_next   = round_cnt;
`endif
        case (state)
            IDLE: begin
                if (key_press) begin
                    state_next = PLAY;
                    clear_all  = 1'b1;
                end
            end
            PLAY: begin
                hide             = eat1 | eat2;
                score1_next      = sat_add(score1, fish_count(eat1));
                score2_next      = sat_add(score2, fish_count(eat2));
                user1_exist_next = user1_exist | user1_shark;
                user2_exist_next = user2_exist | user2_shark;
                // A shark hit hands the round to the other user; user1 has priority.
                win1 = (score1_next == WIN) | user2_shark;
                win2 = (score2_next == WIN) | user1_shark;
                if (win1) begin
                    state_next = U1WIN;
                end else if (win2) begin
                    state_next = U2WIN;
                end
`ifdef GAME_TIME_LIMIT_EN
                else if (play_tick) begin
                    if (round_cnt == RW'(ROUND_FRAMES - 1)) begin
                        // Time up: a tie returns to the start screen keeping scores.
                        if (score1_next > score2_next) begin
                            state_next = U1WIN;
                        end else if (score2_next > score1_next) begin
                            state_next = U2WIN;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        round_cnt_next = round_cnt + RW'(1);
                    end
                end
`endif
            end
            U1WIN, U2WIN: begin
                if (key_press) begin
                    state_next = IDLE;
                    clear_all  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (clear_all) begin
            score1_next      = '0;
            score2_next      = '0;
            user1_exist_next = 1'b0;
            user2_exist_next = 1'b0;
`ifdef GAME_TIME_LIMIT_EN
            round_cnt_next   = '0;
`endif
        end
    end

    // State and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            score1      <= '0;
            score2      <= '0;
            user1_exist <= 1'b0;
            user2_exist <= 1'b0;
            is_start    <= 1'b0;
            is_user1win <= 1'b0;
            is_user2win <= 1'b0;
`ifdef GAME_TIME_LIMIT_EN
            round_cnt   <= '0;
`endif
        end else begin
            state       <= state_next;
            score1      <= score1_next;
            score2      <= score2_next;
            user1_exist <= user1_exist_next;
            user2_exist <= user2_exist_next;
            is_start    <= (state_next != IDLE);
            is_user1win <= (state_next == U1WIN);
            is_user2win <= (state_next == U2WIN);
`ifdef GAME_TIME_LIMIT_EN
            round_cnt   <= round_cnt_next;
`endif
        end
    end

    // One respawn timer per fish; they only advance while the round is live.
    for (genvar i = 0; i < NUM_FISH; i++) begin : g_fish
        fish_respawn_timer #(
            .RESPAWN_FRAMES(RESPAWN_FRAMES)
        ) u_timer (
            .Clk       (Clk),
            .Reset_n   (Reset_n),
            .clear     (clear_all),
            .hide      (hide[i]),
            .frame_tick(play_tick),
            .exist     (fish_exist[i])
        );
    end

endmodule

// File: tb/tb_game_state_controller.sv
// Self-checking bench for game_state_controller with a transaction-level
// game model (scores, per-fish frames-left counters, winner).
module tb_game_state_controller;

    localparam int WIN  = 9;
    localparam int RESP = 120;
    localparam int NF   = 9;
`ifdef GAME_TIME_LIMIT_EN
    localparam int TB_ROUND_FRAMES = 10;
`endif

    logic       Clk, Reset_n, frame_clk, start_key;
    logic [8:0] user1_eat, user2_eat;
    logic       user1_shark, user2_shark;
    logic       is_start, is_user1win, is_user2win;
    logic [7:0] score1, score2;
    logic [8:0] fish_exist;
    logic       user1_exist, user2_exist;

    int checks = 0;
    int errors = 0;

    game_state_controller #(
        .WIN_SCORE     (WIN),
        .RESPAWN_FRAMES(RESP)
`ifdef GAME_TIME_LIMIT_EN
        ,
        .ROUND_FRAMES  (TB_ROUND_FRAMES)
`endif
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .start_key  (start_key),
        .user1_eat  (user1_eat),
        .user2_eat  (user2_eat),
        .user1_shark(user1_shark),
        .user2_shark(user2_shark),
        .is_start   (is_start),
        .is_user1win(is_user1win),
        .is_user2win(is_user2win),
        .score1     (score1),
        .score2     (score2),
        .fish_exist (fish_exist),
        .user1_exist(user1_exist),
        .user2_exist(user2_exist)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    bit m_started;
    int m_winner;
    int m_s1, m_s2;
    int m_hide[NF];
    bit m_u1x, m_u2x;
    int m_round;

    function automatic void m_clear();
        m_s1 = 0; m_s2 = 0; m_u1x = 0; m_u2x = 0; m_round = 0;
        for (int i = 0; i < NF; i++) m_hide[i] = 0;
    endfunction

    function automatic void m_reset();
        m_clear();
        m_started = 0;
        m_winner  = 0;
    endfunction

    function automatic bit m_playing();
        return m_started && (m_winner == 0);
    endfunction

    function automatic void m_key();
        if (!m_started) begin
            m_clear(); m_started = 1; m_winner = 0;
        end else if (m_winner != 0) begin
            m_clear(); m_started = 0; m_winner = 0;
        end
    endfunction

    function automatic void m_tick();
        if (!m_playing()) return;
        for (int i = 0; i < NF; i++) if (m_hide[i] > 0) m_hide[i]--;
`ifdef GAME_TIME_LIMIT_EN
        m_round++;
        if (m_round == TB_ROUND_FRAMES) begin
            if (m_s1 > m_s2) m_winner = 1;
            else if (m_s2 > m_s1) m_winner = 2;
            else m_started = 0;
        end
`endif
    endfunction

    function automatic void m_eat(input logic [8:0] e1, input logic [8:0] e2,
                                  input logic sh1, input logic sh2);
        if (!m_playing()) return;
        for (int i = 0; i < NF; i++) begin
            if (m_hide[i] == 0) begin
                if (e1[i]) begin m_hide[i] = RESP; m_s1++; end
                else if (e2[i]) begin m_hide[i] = RESP; m_s2++; end
            end
        end
        if (m_s1 > WIN) m_s1 = WIN;
        if (m_s2 > WIN) m_s2 = WIN;
        if (sh1) m_u1x = 1;
        if (sh2) m_u2x = 1;
        if (m_s1 == WIN || sh2) m_winner = 1;
        else if (m_s2 == WIN || sh1) m_winner = 2;
    endfunction

    function automatic logic [8:0] m_fish();
        logic [8:0] v;
        v = '0;
        for (int i = 0; i < NF; i++) v[i] = (m_hide[i] != 0);
        return v;
    endfunction

    function automatic logic [29:0] model_vec();
        return {m_started, (m_winner == 1), (m_winner == 2), 8'(m_s1), 8'(m_s2),
                m_fish(), m_u1x, m_u2x};
    endfunction

    function automatic logic [29:0] dut_vec();
        return {is_start, is_user1win, is_user2win, score1, score2,
                fish_exist, user1_exist, user2_exist};
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic do_reset();
        Reset_n = 1'b0; cyc(2); Reset_n = 1'b1; cyc(2);
        m_reset();
    endtask

    task automatic press_key();
        start_key = 1'b1; cyc(4); start_key = 1'b0; cyc(4);
        m_key();
    endtask

    task automatic frame(input int n);
        repeat (n) begin
            frame_clk = 1'b1; cyc(3); frame_clk = 1'b0; cyc(3);
            m_tick();
        end
    endtask

    task automatic eat(input logic [8:0] e1, input logic [8:0] e2,
                       input logic sh1, input logic sh2);
        user1_eat = e1; user2_eat = e2; user1_shark = sh1; user2_shark = sh2;
        cyc(1);
        user1_eat = '0; user2_eat = '0; user1_shark = 1'b0; user2_shark = 1'b0;
        m_eat(e1, e2, sh1, sh2);
    endtask

    task automatic go_play();
        for (int k = 0; k < 3 && !m_playing(); k++) press_key();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        cyc(5);
        checks++; if (is_start !== 1'b0) begin errors++; $display("FAIL reset_is_start: got %b want 0", is_start); end
        checks++; if (score1 !== 8'd0) begin errors++; $display("FAIL reset_score1: got %0d want 0", score1); end
        checks++; if (score2 !== 8'd0) begin errors++; $display("FAIL reset_score2: got %0d want 0", score2); end
        checks++; if (fish_exist !== 9'h000) begin errors++; $display("FAIL reset_fish_exist: got %h want 000", fish_exist); end
        checks++; if ({user1_exist, user2_exist, is_user1win, is_user2win} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {user1_exist, user2_exist, is_user1win, is_user2win});
        end
    endtask

    task automatic test_start_and_eat();
        int lat;
        lat = 0;
        start_key = 1'b1;
        while (lat < 8 && is_start !== 1'b1) begin cyc(1); lat++; end
        checks++; if (is_start !== 1'b1 || lat > 3) begin
            errors++; $display("FAIL start_latency: is_start=%b after %0d cycles, want 1 within 3", is_start, lat);
        end
        cyc(2); start_key = 1'b0; cyc(4);
        m_key();
        eat(9'h001, 9'h000, 1'b0, 1'b0);
        checks++; if (score1 !== 8'd1) begin errors++; $display("FAIL first_eat_score1: got %0d want 1", score1); end
        checks++; if (fish_exist !== 9'h001) begin errors++; $display("FAIL first_eat_fish: got %h want 001", fish_exist); end
        repeat (5) eat(9'h001, 9'h000, 1'b0, 1'b0);
        checks++; if (score1 !== 8'd1) begin errors++; $display("FAIL held_eat_score1: got %0d want 1", score1); end
        checks++; if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL start_eat_state: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_shared_fish();
        logic exp_bit;
        go_play();
        eat(9'h010, 9'h010, 1'b0, 1'b0);
        checks++; if (score1 !== 8'(m_s1) || score2 !== 8'(m_s2)) begin
            errors++; $display("FAIL shared_fish_scores: got %0d/%0d want %0d/%0d", score1, score2, m_s1, m_s2);
        end
        frame(RESP - 1);
        exp_bit = (m_hide[4] != 0);
        checks++; if (fish_exist[4] !== exp_bit) begin
            errors++; $display("FAIL respawn_early: fish4=%b want %b", fish_exist[4], exp_bit);
        end
        frame(1);
        exp_bit = (m_hide[4] != 0);
        checks++; if (fish_exist[4] !== exp_bit) begin
            errors++; $display("FAIL respawn_on_time: fish4=%b want %b", fish_exist[4], exp_bit);
        end
        checks++; if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL shared_fish_state: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_shark();
        go_play();
        eat(9'h004, 9'h000, 1'b0, 1'b0);
        frame(100);
        eat(9'h000, 9'h000, 1'b1, 1'b1);
        checks++; if ({user1_exist, user2_exist, is_user1win, is_user2win} !==
                      {m_u1x, m_u2x, (m_winner == 1), (m_winner == 2)}) begin
            errors++; $display("FAIL both_sharks: got %b want %b",
                {user1_exist, user2_exist, is_user1win, is_user2win},
                {m_u1x, m_u2x, (m_winner == 1), (m_winner == 2)});
        end
        frame(30);
        checks++; if (fish_exist !== m_fish()) begin
            errors++; $display("FAIL respawn_frozen: got %h want %h", fish_exist, m_fish());
        end
        press_key();
        checks++; if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL win_to_idle: got %h want %h", dut_vec(), model_vec());
        end
        go_play();
        eat(9'h000, 9'h000, 1'b1, 1'b0);
        checks++; if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL user1_shark: got %h want %h", dut_vec(), model_vec());
        end
        press_key();
    endtask

    task automatic test_saturate_win2();
        go_play();
        eat(9'h000, 9'h13F, 1'b0, 1'b0);
        checks++; if (score2 !== 8'(m_s2)) begin errors++; $display("FAIL multi_fish_score2: got %0d want %0d", score2, m_s2); end
        frame(RESP);
        eat(9'h000, 9'h001, 1'b0, 1'b0);
        eat(9'h000, 9'h0C0, 1'b0, 1'b0);
        checks++; if (score2 !== 8'(m_s2) || is_user2win !== (m_winner == 2)) begin
            errors++; $display("FAIL saturate_win2: score2=%0d win2=%b want %0d/%b", score2, is_user2win, m_s2, (m_winner == 2));
        end
        checks++; if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL saturate_state: got %h want %h", dut_vec(), model_vec());
        end
        press_key();
        checks++; if (is_start !== 1'b0 || score1 !== 8'd0 || score2 !== 8'd0) begin
            errors++; $display("FAIL win2_to_idle: is_start=%b scores %0d/%0d want 0 0/0", is_start, score1, score2);
        end
    endtask

    task automatic test_random_play();
        go_play();
        for (int n = 0; n < 80; n++) begin
            int op;
            logic [8:0] e1, e2;
            op = $urandom_range(0, 19);
            e1 = 9'($urandom & $urandom & $urandom);
            e2 = 9'($urandom & $urandom & $urandom);
            if (op < 3) frame(1);
            else if (op < 5) press_key();
            else if (op == 5) eat(e1, e2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else eat(e1, e2, 1'b0, 1'b0);
            checks++; if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL random_step%0d op%0d: got %h want %h", n, op, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        go_play();
        eat(9'h100, 9'h001, 1'b0, 1'b0);
        @(posedge Clk); #3;
        Reset_n = 1'b0;
        #1;
        m_reset();
        checks++; if (dut_vec() !== 30'd0) begin
            errors++; $display("FAIL async_reset: got %h want 0", dut_vec());
        end
        cyc(2); Reset_n = 1'b1; cyc(3);
        checks++; if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL after_reset: got %h want %h", dut_vec(), model_vec());
        end
    endtask

`ifdef GAME_TIME_LIMIT_EN
    task automatic test_time_limit();
        do_reset();
        go_play();
        eat(9'h007, 9'h1F0, 1'b0, 1'b0);
        frame(TB_ROUND_FRAMES - 1);
        checks++; if (is_start !== 1'b1 || is_user2win !== 1'b0) begin
            errors++; $display("FAIL timer_early: is_start=%b win2=%b want 1/0", is_start, is_user2win);
        end
        frame(1);
        checks++; if (is_user2win !== 1'b1 || dut_vec() !== model_vec()) begin
            errors++; $display("FAIL timer_win2: got %h want %h", dut_vec(), model_vec());
        end
        press_key();
        go_play();
        eat(9'h001, 9'h002, 1'b0, 1'b0);
        frame(TB_ROUND_FRAMES);
        checks++; if (is_start !== 1'b0 || score1 !== 8'd1 || score2 !== 8'd1) begin
            errors++; $display("FAIL timer_tie: is_start=%b scores %0d/%0d want 0 1/1", is_start, score1, score2);
        end
        press_key();
        checks++; if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL tie_restart: got %h want %h", dut_vec(), model_vec());
        end
    endtask
`endif

    initial begin
        Reset_n = 1'b0; frame_clk = 1'b0; start_key = 1'b0;
        user1_eat = '0; user2_eat = '0; user1_shark = 1'b0; user2_shark = 1'b0;
        m_reset();
        test_reset();
        test_start_and_eat();
        test_shared_fish();
        test_shark();
        test_saturate_win2();
        test_random_play();
        test_reset_mid_play();
`ifdef GAME_TIME_LIMIT_EN
        test_time_limit();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
